pio_button_in: RTL
==================

PIO_BUTTON_IN -- requirements
Module: pio_button_in

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 50000, stable-input cycles required before a change is accepted (1 ms at 50 MHz); legal range 2..65535.
REQ-002 Parameter EDGE_TYPE, default 0, edge captured: 0 = falling, 1 = rising, 2 = any.
REQ-003 Port clk, input, 1, sole clock; all state on its rising edge.
REQ-004 Port reset, input, 1; reset is synchronous and active-high.
REQ-005 Port address, input, 2, Avalon-MM slave register select.
REQ-006 Port chipselect, input, 1, slave select.
REQ-007 Port write_n, input, 1, active-low write strobe.
REQ-008 Port writedata, input, 8, write data.
REQ-009 Port readdata, output, 8, registered read data.
REQ-010 Port in_port, input, 8, asynchronous push-button inputs, active-low.
REQ-011 Port irq, output, 1, level interrupt to the processor.

Function
REQ-012 Register map: 0 = debounced data (RO); 1 = direction (reads 8'h00, writes ignored); 2 = interruptmask (RW); 3 = edgecapture (read, write-1-to-clear).
REQ-013 Each in_port bit passes through a two-flop synchronizer before any other logic.
REQ-014 Per bit: when the synchronized value equals the stable value, the debounce counter clears to 0.
REQ-015 Per bit: when they differ, the counter increments. When it reaches DEBOUNCE_CYCLES-1, the stable value takes the synchronized value and the counter clears on the same edge.
REQ-016 A glitch shorter than DEBOUNCE_CYCLES clocks never changes the stable value; any bounce restarts the count from 0.
REQ-017 Latency from an in_port change to the stable value is 2 + DEBOUNCE_CYCLES clocks.
REQ-018 An edge is detected when the stable value changes in the direction selected by EDGE_TYPE. Detection uses the stable value and its one-cycle-delayed copy.
REQ-019 A detected edge sets the corresponding edgecapture bit one clock after the stable value changes.
REQ-020 A write to address 3 clears every edgecapture bit whose writedata bit is 1. If a set and a clear hit the same bit in the same cycle, the set wins.
REQ-021 A write to address 2 loads interruptmask from writedata[7:0]. Writes take effect only when chipselect=1 and write_n=0.
REQ-022 irq = OR of (edgecapture AND interruptmask), driven from registers with no combinational path from bus inputs.
REQ-023 readdata is updated every clock with the mux output for the current address, giving read latency 1. Unselected addresses return 0.

Reset
REQ-024 While reset=1 on a clock edge: synchronizers, stable values and delayed copies = 8'hFF; counters = 0; interruptmask = 0; edgecapture = 0; readdata = 0; irq = 0.
REQ-025 Reset asserted mid-debounce discards the partial count. No edge is captured in the first cycle after release, even if in_port is low.

Structure
REQ-026 Shared package pio_pkg holds the register address constants (ADDR_DATA, ADDR_DIR, ADDR_MASK, ADDR_EDGE) and the EDGE_TYPE encodings.
REQ-027 Single-bit sub-module pio_debounce contains the synchronizer, counter, stable register and edge detect; it is instantiated 8 times.
REQ-028 Counter width is the minimum that holds DEBOUNCE_CYCLES-1, computed with $clog2.

Verification (bench uses DEBOUNCE_CYCLES=4, EDGE_TYPE=0)
REQ-029 Reset scenario: reset for 3 clocks with in_port=8'hFF, then read addresses 0 and 3 -> readdata 8'hFF and 8'h00, irq=0.
REQ-030 Clean press: in_port[2] goes 1->0 and stays low. Required response: data bit 2 = 0 exactly 6 clocks later; edgecapture = 8'h04 one clock after that; irq stays 0 because mask = 0.
REQ-031 Bounce: in_port[0] toggles low 3 clocks, high 1, low 3, high. Required response: stable value never changes, and edgecapture stays 8'h00.
REQ-032 Interrupt: write mask 8'h04, then press bit 2 -> irq=1. Write 8'h04 to address 3 -> edgecapture = 0 and irq = 0 on the next clock.
REQ-033 Simultaneous events: an edge on bit 5 coincides with a W1C write of 8'h20. Required response: edgecapture bit 5 remains 1. A separate write of 8'h00 to address 3 clears nothing.
REQ-034 Reset mid-debounce: assert reset at count 2 with bit 1 low, then release with in_port[1] still low. Required response: no edgecapture bit set before 6 clocks after release; bit 1 captured once after 6 clocks.

Source files
------------

// File: rtl/pio_pkg.sv
// Shared definitions for the push-button PIO: register map and edge-select encodings.
package pio_pkg;

  typedef enum logic [1:0] {
    ADDR_DATA = 2'd0,
    ADDR_DIR  = 2'd1,
    ADDR_MASK = 2'd2,
    ADDR_EDGE = 2'd3
  } addr_e;

  typedef enum logic [1:0] {
    EDGE_FALLING = 2'd0,
    EDGE_RISING  = 2'd1,
    EDGE_ANY     = 2'd2
  } edge_type_e;

  // Edge detect on a debounced level and its one-cycle-delayed copy.
  function automatic logic edge_hit(logic cur, logic prev, int unsigned etype);
    logic hit;
    hit = 1'b0;
    case (etype)
      int'(EDGE_FALLING): hit = prev & ~cur;
      int'(EDGE_RISING):  hit = ~prev & cur;
      default:            hit = prev ^ cur;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/pio_debounce.sv
// One button bit: two-flop synchronizer, stability counter, debounced level and edge pulse.
module pio_debounce
  import pio_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned EDGE_TYPE       = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic stable,
  output logic edge_det
);

  localparam int unsigned     CW   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          stable_d;
  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1    <= 1'b1;
      sync2    <= 1'b1;
      stable   <= 1'b1;
      stable_d <= 1'b1;
      count    <= '0;
    end else begin
      sync1    <= din;
      sync2    <= sync1;
      stable_d <= stable;
      // Any return to the accepted level restarts the count, so bounces never accumulate.
      if (sync2 == stable) begin
        count <= '0;
      end else if (count == LAST) begin
        stable <= sync2;
        count  <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

  assign edge_det = edge_hit(stable, stable_d, EDGE_TYPE);

endmodule

// File: rtl/pio_button_in.sv
// Avalon-MM push-button input port: 8 debounced inputs, edge capture with W1C and masked level irq.
module pio_button_in
  import pio_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned EDGE_TYPE       = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] address,
  input  logic       chipselect,
  input  logic       write_n,
  input  logic [7:0] writedata,
  output logic [7:0] readdata,
  input  logic [7:0] in_port,
  output logic       irq
);

  logic [7:0] stable;
  logic [7:0] edge_det;
  logic [7:0] mask;
  logic [7:0] edgecapture;
  logic [7:0] rd_mux;
  logic       wr_en;

  for (genvar i = 0; i < 8; i++) begin : g_bit
    pio_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .EDGE_TYPE      (EDGE_TYPE)
    ) u_debounce (
      .clk     (clk),
      .reset   (reset),
      .din     (in_port[i]),
      .stable  (stable[i]),
      .edge_det(edge_det[i])
    );
  end

  assign wr_en = chipselect & ~write_n;

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA: rd_mux = stable;
      ADDR_DIR:  rd_mux = '0;
      ADDR_MASK: rd_mux = mask;
      ADDR_EDGE: rd_mux = edgecapture;
      default:   rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mask        <= '0;
      edgecapture <= '0;
      readdata    <= '0;
    end else begin
      if (wr_en && address == ADDR_MASK) begin
        mask <= writedata;
      end
      // New edges are ORed in after the clear so a coincident set wins.
      if (wr_en && address == ADDR_EDGE) begin
        edgecapture <= (edgecapture & ~writedata) | edge_det;
      end else begin
        edgecapture <= edgecapture | edge_det;
      end
      readdata <= rd_mux;
    end
  end

  assign irq = |(edgecapture & mask);

endmodule
